// File: rtl/data_bus_dma_if.sv
// Data-bus bundle shared by the DMA initiator and a memory-side responder:
// request/grant address phase, then a single rvalid response per request.
interface ibex_data_bus;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [6:0]  wdata_intg;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [6:0]  rdata_intg;
    logic        err;

    modport master (
        output req, addr, we, be, wdata, wdata_intg,
        input  gnt, rvalid, rdata, rdata_intg, err
    );

    modport slave (
        input  req, addr, we, be, wdata, wdata_intg,
        output gnt, rvalid, rdata, rdata_intg, err
    );
endinterface

// File: rtl/data_bus_dma.sv
// Single-channel word-copy DMA: reads one word from src and writes it to dst,
// repeating len times, with at most one bus transaction outstanding.
module data_bus_dma #(
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [2:0]           dbg_state,
    ibex_data_bus.master         data_bus
);
    // Bus handshake: an address phase completes on the cycle req && gnt are
    // both high (req/addr/we/be/wdata held until then); the response is the
    // next rvalid, which is only listened to in the matching *_WAIT state.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        FINISH  = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          src_q, src_d;
    logic [31:0]          dst_q, dst_d;
    logic [31:0]          hold_q, hold_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic                 error_q, error_d;

    // Integrity bits on the read data are not checked by this engine.
    logic unused_rdata_intg;
    assign unused_rdata_intg = ^data_bus.rdata_intg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            hold_q      <= '0;
            remaining_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            hold_q      <= hold_d;
            remaining_q <= remaining_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        hold_d      = hold_q;
        remaining_d = remaining_q;
        error_d     = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (len != '0) begin
                        src_d       = src_addr & 32'hFFFF_FFFC;
                        dst_d       = dst_addr & 32'hFFFF_FFFC;
                        remaining_d = len;
                        state_d     = RD_REQ;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            RD_REQ: begin
                if (data_bus.gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (data_bus.rvalid) begin
                    if (data_bus.err) begin
                        error_d = 1'b1;
                        state_d = FINISH;
                    end else begin
                        hold_d  = data_bus.rdata;
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (data_bus.gnt) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (data_bus.rvalid) begin
                    if (data_bus.err) begin
                        error_d = 1'b1;
                        state_d = FINISH;
                    end else begin
                        // 32-bit adds wrap naturally past 0xFFFF_FFFC.
                        src_d       = src_q + 32'd4;
                        dst_d       = dst_q + 32'd4;
                        remaining_d = remaining_q - LEN_WIDTH'(1);
                        state_d     = (remaining_d != '0) ? RD_REQ : FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus outputs depend on state only, so they cannot move while waiting for gnt.
    always_comb begin
        data_bus.req   = 1'b0;
        data_bus.we    = 1'b0;
        data_bus.be    = 4'h0;
        data_bus.addr  = 32'h0;
        data_bus.wdata = 32'h0;
        case (state_q)
            RD_REQ: begin
                data_bus.req  = 1'b1;
                data_bus.be   = 4'hF;
                data_bus.addr = src_q;
            end
            WR_REQ: begin
                data_bus.req   = 1'b1;
                data_bus.we    = 1'b1;
                data_bus.be    = 4'hF;
                data_bus.addr  = dst_q;
                data_bus.wdata = hold_q;
            end
            default: begin
            end
        endcase
    end

    assign data_bus.wdata_intg = 7'b0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign error     = error_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_data_bus_dma.sv
// Bench for data_bus_dma: a memory responder with programmable grant stalls and
// error injection, plus a transaction-level model of the expected bus traffic.
module tb_data_bus_dma;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   src_addr = 32'h0;
    logic [31:0]   dst_addr = 32'h0;
    logic [LW-1:0] len = '0;
    logic          busy, done, error;
    logic [2:0]    dbg_state;

    ibex_data_bus bus ();

    data_bus_dma #(.LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .dbg_state (dbg_state),
        .data_bus  (bus.master)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    // Expected bus transactions in order: {we, addr, wdata}.
    logic [64:0] exp_q[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] rd_log[$];
    int          gnt_delay = 0;
    int          err_rd_idx = -1;
    int          err_wr_idx = -1;
    int          rd_idx = 0;
    int          wr_idx = 0;
    int          wr_count = 0;
    logic        inject_rvalid = 1'b0;
    logic        req_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Memory responder and bus compare: grants after gnt_delay stall cycles,
    // answers one cycle after the grant, checks every address phase.
    initial begin : bus_monitor
        logic        pend, pend_err, stall;
        logic [31:0] pend_data;
        logic [63:0] snap, cur;
        logic [64:0] e;
        int          stall_cnt;
        pend = 1'b0; pend_err = 1'b0; stall = 1'b0; pend_data = '0;
        snap = '0; stall_cnt = 0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rdata_intg = '0; bus.err = 1'b0;
        forever begin
            @(negedge clk);
            bus.gnt        = 1'b0;
            bus.rvalid     = 1'b0;
            bus.err        = 1'b0;
            bus.rdata      = 32'hDEAD_BEEF;
            bus.rdata_intg = 7'($urandom);
            if (!rst_n) begin
                pend = 1'b0; stall = 1'b0; stall_cnt = 0;
            end else begin
                if (inject_rvalid) begin
                    bus.rvalid = 1'b1; bus.err = 1'b1; bus.rdata = 32'h0BAD_0BAD;
                    inject_rvalid = 1'b0;
                end
                if (pend) begin
                    bus.rvalid = 1'b1; bus.rdata = pend_data; bus.err = pend_err;
                    pend = 1'b0;
                end
                cur = {bus.addr, bus.wdata};
                if (bus.req) begin
                    req_seen = 1'b1;
                    check("req_be", 64'(bus.be), 64'hF);
                    if (stall) check("stall_hold", cur, snap);
                    if (stall_cnt < gnt_delay) begin
                        stall_cnt++;
                        stall = 1'b1;
                        snap  = {bus.addr, bus.we ? bus.wdata : 32'h0} | {32'h0, bus.wdata};
                        snap  = cur;
                    end else begin
                        bus.gnt = 1'b1;
                        stall = 1'b0; stall_cnt = 0;
                        check("hs_expected", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("hs_we", 64'(bus.we), 64'(e[64]));
                            check("hs_addr", 64'(bus.addr), 64'(e[63:32]));
                            if (e[64]) begin
                                check("hs_wdata", 64'(bus.wdata), 64'(e[31:0]));
                                check("hs_wintg", 64'(bus.wdata_intg), 64'd0);
                            end
                        end
                        if (!bus.we) begin
                            pend_data = mem_rd(bus.addr);
                            pend_err  = (rd_idx == err_rd_idx);
                            rd_idx++;
                            rd_log.push_back(bus.addr);
                        end else begin
                            pend_data = 32'h0;
                            pend_err  = (wr_idx == err_wr_idx);
                            wr_idx++;
                            wr_count++;
                            if (!pend_err) mem[bus.addr] = bus.wdata;
                        end
                        pend = 1'b1;
                    end
                end else begin
                    if (stall) check("req_held", 64'(bus.req), 64'd1);
                    stall = 1'b0; stall_cnt = 0;
                end
            end
        end
    end

    // Builds the expected traffic from the copy rules, runs one transfer with
    // random start noise while busy, and checks timing and status.
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int dly, input int erd, input int ewr,
                            output int lat, output int bcyc);
        logic [31:0] sa, da;
        int          nreq, c, dcyc;
        logic        exp_err, got;
        sa = s & 32'hFFFF_FFFC;
        da = d & 32'hFFFF_FFFC;
        exp_q.delete();
        nreq = 0;
        exp_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, sa + 32'(4 * i), 32'h0});
            nreq++;
            if (i == erd) begin exp_err = 1'b1; break; end
            exp_q.push_back({1'b1, da + 32'(4 * i), mem_rd(sa + 32'(4 * i))});
            nreq++;
            if (i == ewr) begin exp_err = 1'b1; break; end
        end
        gnt_delay = dly; err_rd_idx = erd; err_wr_idx = ewr; rd_idx = 0; wr_idx = 0;
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = LW'(n);
        c = cyc;
        got = 1'b0; bcyc = 0; dcyc = c;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (k == 0) check("err_cleared", 64'(error), 64'd0);
            if (busy) bcyc++;
            if (done) begin got = 1'b1; dcyc = cyc; break; end
            start    = 1'($urandom_range(0, 1));
            src_addr = $urandom;
            dst_addr = $urandom;
            len      = LW'($urandom_range(0, 8));
        end
        start = 1'b0;
        check("done_seen", 64'(got), 64'd1);
        lat = dcyc - c + 1;
        check("latency", 64'(lat), 64'(2 + nreq * (2 + dly)));
        check("busy_cycles", 64'(bcyc), 64'(dcyc - c));
        check("error_flag", 64'(error), 64'(exp_err));
        check("exp_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin : main
        int          lat, bc, wc0, c, n, mode, erd, ewr;
        logic [31:0] v, s, d;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_req", 64'(bus.req), 64'd0);
        check("rst_addr", 64'(bus.addr), 64'd0);
        check("rst_we_be", 64'({bus.we, bus.be}), 64'd0);
        check("rst_wdata", 64'({bus.wdata, bus.wdata_intg}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Three-word copy with a zero-wait responder.
        mem[32'h1000] = 32'hAAAA_0001;
        mem[32'h1004] = 32'hBBBB_0002;
        mem[32'h1008] = 32'hCCCC_0003;
        wc0 = wr_count;
        run_xfer(32'h1000, 32'h2000, 3, 0, -1, -1, lat, bc);
        check("copy3_latency", 64'(lat), 64'd14);
        check("copy3_w0", 64'(mem_rd(32'h2000)), 64'hAAAA_0001);
        check("copy3_w1", 64'(mem_rd(32'h2004)), 64'hBBBB_0002);
        check("copy3_w2", 64'(mem_rd(32'h2008)), 64'hCCCC_0003);
        check("copy3_writes", 64'(wr_count - wc0), 64'd3);
        check("copy3_error", 64'(error), 64'd0);

        // Zero length: no bus activity at all.
        req_seen = 1'b0;
        run_xfer(32'h1000, 32'h2000, 0, 0, -1, -1, lat, bc);
        check("len0_no_req", 64'(req_seen), 64'd0);
        check("len0_latency", 64'(lat), 64'd2);
        check("len0_busy", 64'(bc), 64'd1);

        // Five-cycle grant stall on every request.
        run_xfer(32'h1100, 32'h2100, 2, 5, -1, -1, lat, bc);
        check("stall_latency", 64'(lat), 64'd30);
        check("stall_w1", 64'(mem_rd(32'h2104)), 64'(mem_rd(32'h1104)));

        // Bus error on the second read of four.
        wc0 = wr_count;
        run_xfer(32'h1200, 32'h2200, 4, 0, 1, -1, lat, bc);
        check("rderr_writes", 64'(wr_count - wc0), 64'd1);
        check("rderr_flag", 64'(error), 64'd1);
        repeat (3) @(negedge clk);
        check("rderr_sticky", 64'(error), 64'd1);
        run_xfer(32'h1300, 32'h2300, 1, 0, -1, -1, lat, bc);
        check("rderr_recover", 64'(error), 64'd0);

        // Source address wraps past the top of the address space.
        rd_log.delete();
        run_xfer(32'hFFFF_FFFC, 32'h5000, 2, 0, -1, -1, lat, bc);
        check("wrap_nreads", 64'(rd_log.size()), 64'd2);
        if (rd_log.size() == 2) begin
            check("wrap_rd0", 64'(rd_log[0]), 64'hFFFF_FFFC);
            check("wrap_rd1", 64'(rd_log[1]), 64'h0000_0000);
        end

        // Reset while the first write response is in flight.
        exp_q.delete();
        exp_q.push_back({1'b0, 32'h1400, 32'h0});
        exp_q.push_back({1'b1, 32'h2400, mem_rd(32'h1400)});
        gnt_delay = 0; err_rd_idx = -1; err_wr_idx = -1; rd_idx = 0; wr_idx = 0;
        @(negedge clk);
        start = 1'b1; src_addr = 32'h1400; dst_addr = 32'h2400; len = LW'(2);
        c = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && cyc != c + 4; k++) @(negedge clk);
        check("rst_mid_reached", 64'(cyc), 64'(c + 4));
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_req", 64'(bus.req), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        req_seen = 1'b0;
        inject_rvalid = 1'b1;
        repeat (4) @(negedge clk);
        check("late_rvalid_busy", 64'(busy), 64'd0);
        check("late_rvalid_req", 64'(req_seen), 64'd0);
        check("late_rvalid_err", 64'(error), 64'd0);
        v = mem_rd(32'h3000);
        run_xfer(32'h3000, 32'h3000, 1, 0, -1, -1, lat, bc);
        check("post_rst_data", 64'(mem_rd(32'h3000)), 64'(v));
        check("post_rst_latency", 64'(lat), 64'd6);

        // Randomized transfers with random stalls, errors and misaligned addresses.
        for (int t = 0; t < 12; t++) begin
            n    = $urandom_range(0, 6);
            s    = (32'h0001_0000 + 32'($urandom_range(0, 4095)) * 4) | 32'($urandom_range(0, 3));
            d    = (32'h0080_0000 + 32'($urandom_range(0, 4095)) * 4) | 32'($urandom_range(0, 3));
            mode = $urandom_range(0, 3);
            erd  = (mode == 0) ? $urandom_range(0, n) : -1;
            ewr  = (mode == 1) ? $urandom_range(0, n) : -1;
            run_xfer(s, d, n, $urandom_range(0, 3), erd, ewr, lat, bc);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/data_bus_dma.md
DATA_BUS_DMA -- requirements
Module: data_bus_dma

Interface
REQ-001 Parameter LEN_WIDTH, default 16: width of the transfer length in words.
REQ-002 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 Port rst_n, input, 1: asynchronous active-low reset.
REQ-004 Port start, input, 1: single-cycle request to begin a transfer; sampled only in IDLE.
REQ-005 Port src_addr, input, 32: source byte address; bits [1:0] ignored (treated as 0).
REQ-006 Port dst_addr, input, 32: destination byte address; bits [1:0] ignored.
REQ-007 Port len, input, LEN_WIDTH: number of 32-bit words to copy.
REQ-008 Port busy, output, 1: high from the cycle after an accepted start until the cycle done pulses, inclusive.
REQ-009 Port done, output, 1: single-cycle pulse at the end of every accepted transfer.
REQ-010 Port error, output, 1: sticky bus-error flag; cleared by the next accepted start.
REQ-011 Port data_bus, ibex_data_bus.master: req, addr[31:0], we, be[3:0], wdata[31:0], wdata_intg[6:0] out; gnt, rvalid, rdata[31:0], rdata_intg[6:0], err in.

Function
REQ-012 The block SHALL act as the bus initiator for the data-bus req/gnt/rvalid protocol, with at most one outstanding transaction.
REQ-013 FSM states SHALL be IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
REQ-014 In IDLE with start=1 and len!=0: latch src/dst (with [1:0]=0), set remaining=len, clear error, and go to RD_REQ.
REQ-015 In IDLE with start=1 and len=0: clear error, go to FINISH, and issue no bus request.
REQ-016 In RD_REQ: req=1, we=0, be=4'hF, addr=current src; addr/we/be SHALL hold stable until gnt; on gnt go to RD_WAIT, deasserting req in the following cycle.
REQ-017 In RD_WAIT: on rvalid with err=0, capture rdata into a 32-bit holding register and go to WR_REQ; on rvalid with err=1, set error and go to FINISH.
REQ-018 In WR_REQ: req=1, we=1, be=4'hF, addr=current dst, wdata=holding register, wdata_intg=7'b0; all held stable until gnt; on gnt go to WR_WAIT.
REQ-019 In WR_WAIT, on rvalid:
- err=1: set error, go to FINISH.
- otherwise: src+=4, dst+=4, remaining-=1; go to RD_REQ if the new remaining is nonzero, else FINISH.
REQ-020 Address increments SHALL wrap modulo 2^32 (0xFFFF_FFFC+4=0x0000_0000); no range checking.
REQ-021 FINISH SHALL last exactly one cycle with done=1, then return to IDLE; busy is deasserted in IDLE.
REQ-022 start while not in IDLE SHALL be ignored, with no effect on the latched parameters.
REQ-023 rvalid arriving in RD_REQ, WR_REQ, IDLE or FINISH SHALL be ignored; gnt outside a *_REQ state SHALL be ignored.
REQ-024 rdata_intg SHALL be ignored.
REQ-025 Minimum per-word cost SHALL be 4 cycles (gnt in the same cycle as req, rvalid one cycle after gnt); total latency for N words with zero-wait slaves is 4N+2 cycles from start to done.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force: state=IDLE, req=0, we=0, be=0, addr=0, wdata=0, wdata_intg=0, busy=0, done=0, error=0; holding and counter registers=0.
REQ-027 Reset mid-transfer SHALL abandon the transaction without further bus activity; a late rvalid after reset release SHALL be ignored per REQ-023.

Verification
REQ-028 Copy with zero-wait memory model: src=0x1000, dst=0x2000, len=3, src words A,B,C.
- Writes A,B,C to 0x2000/0x2004/0x2008.
- done after 14 cycles; error=0.
REQ-029 len=0 with start=1:
- No req asserted.
- done pulses 2 cycles after start; busy high 1 cycle.
REQ-030 Slave stalls gnt for 5 cycles in RD_REQ and WR_REQ: addr, we, be and wdata constant for the whole stall; copy result correct.
REQ-031 err=1 on the second read, len=4:
- Exactly one write performed.
- error=1, done pulses.
- Next start with len=1 clears error and succeeds.
REQ-032 Wrap: src=0xFFFF_FFFC, len=2 reads 0xFFFF_FFFC then 0x0000_0000.
REQ-033 Reset pulse during WR_WAIT:
- req=0 and busy=0 immediately.
- Injected rvalid after reset release is ignored.
- Start with src=dst=0x3000, len=1 then works.
